// File: rtl/core_fetch_queue.sv
// core_fetch_queue: instruction prefetch queue placed in front of the execute stage.
//
// Sequential fetches are issued ahead of execution into a DEPTH-entry FIFO. Each entry holds
// the instruction word and its PC+1 (the return/next address the execute stage expects).
// A redirect (jump, interrupt, RTI) flushes the queue and reloads the fetch PC. A hold
// (boot, pause, HLT, memory-instruction cycles) suppresses new requests and keeps the queue.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, a word granted into an empty queue is presented at the head in the same
//   cycle. If it is also taken that cycle, it is never written into the queue.
//
// Ports:
//   i_clk           clock, all state updates on the rising edge
//   i_rstn          asynchronous active-low reset
//   o_fetchAddr     word address of the requested fetch (the fetch PC)
//   o_fetchReq      fetch request this cycle
//   i_fetchGnt      memory serviced the request; i_fetchData valid in the same cycle
//   i_fetchData     instruction word at o_fetchAddr
//   i_hold          suppress new requests, keep queue contents
//   i_redirect      flush the queue and load the fetch PC from i_redirectAddr
//   i_redirectAddr  new fetch PC
//   o_instrValid    head entry valid
//   o_instr         head instruction, zero when not valid
//   o_instrPC       head instruction address + 1, zero when not valid
//   i_instrTake     execute stage consumes the head this cycle
//   o_count         number of valid entries
module core_fetch_queue #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 15,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  output logic [ADDR_W-1:0]        o_fetchAddr,
  output logic                     o_fetchReq,
  input  logic                     i_fetchGnt,
  input  logic [DATA_W-1:0]        i_fetchData,
  input  logic                     i_hold,
  input  logic                     i_redirect,
  input  logic [ADDR_W-1:0]        i_redirectAddr,
  output logic                     o_instrValid,
  output logic [DATA_W-1:0]        o_instr,
  output logic [ADDR_W-1:0]        o_instrPC,
  input  logic                     i_instrTake,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetchPc_q;
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0] pcMem    [DEPTH];

  logic              full, empty;
  logic              fetchReq, grant;
  logic              bypass;
  logic              headValid, take;
  logic              push, pop;
  logic [ADDR_W-1:0] fetchPcInc;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign fetchPcInc = fetchPc_q + 1'b1;

  // Request depends only on registered state and hold/redirect, never on take, so a full
  // queue does not request even when the head is popped in the same cycle. Gated by reset
  // so no request is visible while the core is held in reset.
  assign fetchReq = i_rstn & ~i_hold & ~i_redirect & ~full;
  assign grant    = fetchReq & i_fetchGnt;

`ifdef FETCHQ_BYPASS_EN
  // grant already excludes redirect, so a redirect cycle never bypasses.
  assign bypass = empty & grant;
`else
  assign bypass = 1'b0;
`endif

  assign headValid = ~empty | bypass;
  assign take      = i_instrTake & headValid & ~i_redirect;

  // A bypassed word that is taken immediately never touches the storage.
  assign push = grant & ~(bypass & take);
  assign pop  = take & ~bypass;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetchPc_q <= RESET_ADDR;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else if (i_redirect) begin
      fetchPc_q <= i_redirectAddr;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      if (grant) fetchPc_q <= fetchPcInc;
      if (push)  wrPtr_q   <= wrPtr_q + 1'b1;
      if (pop)   rdPtr_q   <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instrMem[wrPtr_q] <= i_fetchData;
      pcMem[wrPtr_q]    <= fetchPcInc;
    end
  end

  always_comb begin
    o_instr   = '0;
    o_instrPC = '0;
    if (bypass) begin
      o_instr   = i_fetchData;
      o_instrPC = fetchPcInc;
    end else if (!empty) begin
      o_instr   = instrMem[rdPtr_q];
      o_instrPC = pcMem[rdPtr_q];
    end
  end

  assign o_fetchAddr  = fetchPc_q;
  assign o_fetchReq   = fetchReq;
  assign o_instrValid = headValid;
  assign o_count      = count_q;

endmodule

// File: tb/tb_core_fetch_queue.sv
module tb_core_fetch_queue;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PC_MASK = (1 << ADDR_W) - 1;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              rstn;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchReq;
  logic              fetchGnt;
  logic [DATA_W-1:0] fetchData;
  logic              hold;
  logic              redirect;
  logic [ADDR_W-1:0] redirectAddr;
  logic              instrValid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instrPC;
  logic              instrTake;
  logic [2:0]        count;

  core_fetch_queue #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_ADDR('0)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .o_fetchAddr   (fetchAddr),
    .o_fetchReq    (fetchReq),
    .i_fetchGnt    (fetchGnt),
    .i_fetchData   (fetchData),
    .i_hold        (hold),
    .i_redirect    (redirect),
    .i_redirectAddr(redirectAddr),
    .o_instrValid  (instrValid),
    .o_instr       (instr),
    .o_instrPC     (instrPC),
    .i_instrTake   (instrTake),
    .o_count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  // Reference model: a plain queue of expected entries plus the expected fetch PC.
  entry_t      expQ[$];
  int unsigned modelPc;
  int          compared;
  int          mismatched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. Inputs change at the falling edge; the request side is checked
  // 1 ns later, the monitor checks the head at +2 ns, and the model advances at +3 ns.
  task automatic doCycle(input bit h, input bit r, input logic [ADDR_W-1:0] ra,
                         input bit g, input bit t, input logic [DATA_W-1:0] d);
    bit     expReq;
    bit     granted;
    bit     pushedEarly;
    entry_t e;
    @(negedge clk);
    hold         = h;
    redirect     = r;
    redirectAddr = ra;
    fetchGnt     = g;
    instrTake    = t;
    fetchData    = d;
    #1;
    expReq = !h && !r && (expQ.size() < DEPTH);
    check("fetchReq", {31'd0, fetchReq}, {31'd0, expReq});
    check("count", {29'd0, count}, expQ.size());
    if (expReq) check("fetchAddr", {17'd0, fetchAddr}, modelPc);
    granted     = expReq && g;
    e.word      = d;
    e.pc        = ADDR_W'((modelPc + 1) & PC_MASK);
    pushedEarly = 1'b0;
    if (BYPASS && granted && expQ.size() == 0) begin
      expQ.push_back(e);
      pushedEarly = 1'b1;
    end
    #2;
    if (r) begin
      expQ.delete();
      modelPc = ra;
    end else if (granted) begin
      if (!pushedEarly) expQ.push_back(e);
      modelPc = (modelPc + 1) & PC_MASK;
    end
  endtask

  // Monitor: compares whatever the DUT presents at the head against the scoreboard front
  // and pops it when the execute stage takes it.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() == 0) begin
        check("empty.valid", {31'd0, instrValid}, 32'd0);
        check("empty.instr", {16'd0, instr}, 32'd0);
        check("empty.pc", {17'd0, instrPC}, 32'd0);
      end else begin
        check("head.valid", {31'd0, instrValid}, 32'd1);
        check("head.instr", {16'd0, instr}, {16'd0, expQ[0].word});
        check("head.pc", {17'd0, instrPC}, {17'd0, expQ[0].pc});
        if (instrTake && !redirect && rstn) void'(expQ.pop_front());
      end
    end
  end

  function automatic logic [DATA_W-1:0] memWord(input int unsigned a);
    memWord = DATA_W'(32'h1000 + a);
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    modelPc    = 0;
    rstn         = 1'b0;
    hold         = 1'b0;
    redirect     = 1'b0;
    redirectAddr = '0;
    fetchGnt     = 1'b0;
    fetchData    = '0;
    instrTake    = 1'b0;

    // Reset state.
    #7;
    check("rst.count", {29'd0, count}, 32'd0);
    check("rst.req", {31'd0, fetchReq}, 32'd0);
    check("rst.addr", {17'd0, fetchAddr}, 32'd0);
    check("rst.valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Fill from reset: requests at 0..3, then full.
    for (int i = 0; i < 6; i++) doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    // Drain with take every cycle while memory keeps granting.
    for (int i = 0; i < 12; i++) doCycle(0, 0, '0, 1, 1, memWord(modelPc));

    // Empty the queue, queue three entries, then redirect with grant and take.
    for (int i = 0; i < 5; i++) doCycle(0, 0, '0, 0, 1, 16'h0);
    for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    doCycle(0, 1, 15'h0040, 1, 1, 16'hDEAD);
    for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    for (int i = 0; i < 4; i++) doCycle(0, 0, '0, 0, 1, 16'h0);

    // PC wrap at the top of the address space.
    doCycle(0, 1, 15'h7FFE, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    for (int i = 0; i < 5; i++) doCycle(0, 0, '0, 0, 1, 16'h0);

    // Hold with two entries: takes drain it, grants ignored, release requests at once.
    doCycle(0, 1, 15'h0100, 0, 0, 16'h0);
    for (int i = 0; i < 2; i++) doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    doCycle(1, 0, '0, 1, 1, 16'h1111);
    doCycle(1, 0, '0, 1, 0, 16'h2222);
    doCycle(1, 0, '0, 1, 1, 16'h3333);
    doCycle(1, 0, '0, 1, 0, 16'h4444);
    doCycle(1, 1, 15'h0200, 1, 0, 16'h5555);
    doCycle(1, 0, '0, 1, 0, 16'h6666);
    doCycle(0, 0, '0, 1, 0, memWord(modelPc));
    for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 0, 1, 16'h0);

    // Grant into an empty queue with take in the same cycle.
    doCycle(0, 0, '0, 1, 1, 16'hBEEF);
    for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 0, 1, 16'h0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      doCycle($urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0, ADDR_W'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, DATA_W'($urandom));
    end

    // Asynchronous reset in the middle of traffic discards all entries immediately.
    for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 1, 0, DATA_W'($urandom));
    @(negedge clk);
    fetchGnt  = 1'b0;
    instrTake = 1'b0;
    #4;
    rstn = 1'b0;
    expQ.delete();
    modelPc = 0;
    #1;
    check("midrst.count", {29'd0, count}, 32'd0);
    check("midrst.valid", {31'd0, instrValid}, 32'd0);
    check("midrst.req", {31'd0, fetchReq}, 32'd0);
    check("midrst.instr", {16'd0, instr}, 32'd0);
    check("midrst.addr", {17'd0, fetchAddr}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      doCycle($urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0, ADDR_W'($urandom),
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, DATA_W'($urandom));
    end

    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
